// File: rtl/home_inventory_wb_regs.sv
// Wishbone register window for the inventory sensing core: control, IRQ and
// per-channel saturating event counters with a snapshot bank.
module home_inventory_wb_regs #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned WIN_W     = 12,
    parameter logic [31:0] VERSION   = 32'h0000_0002
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [7:0]        core_status,
    input  logic [NUM_CH-1:0] ch_event_i,
    output logic              ctrl_enable,
    output logic              ctrl_start,
    output logic [NUM_CH-1:0] irq_en,
    output logic              irq_o
);

    localparam logic [WIN_W-1:0] OFF_ID     = WIN_W'(12'h000);
    localparam logic [WIN_W-1:0] OFF_VER    = WIN_W'(12'h004);
    localparam logic [WIN_W-1:0] OFF_CAPS   = WIN_W'(12'h008);
    localparam logic [WIN_W-1:0] OFF_CTRL   = WIN_W'(12'h100);
    localparam logic [WIN_W-1:0] OFF_IRQEN  = WIN_W'(12'h104);
    localparam logic [WIN_W-1:0] OFF_STATUS = WIN_W'(12'h108);
    localparam logic [WIN_W-1:0] OFF_ISTAT  = WIN_W'(12'h10C);
    localparam logic [WIN_W-1:0] OFF_CNT    = WIN_W'(12'h200);
    localparam logic [WIN_W-1:0] OFF_SNAP   = WIN_W'(12'h280);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic                ack_q;
    logic [31:0]         dat_q;
    logic                enable_q, enable_d;
    logic                start_q, start_d;
    logic [NUM_CH-1:0]   irq_en_q, irq_en_d;
    logic [NUM_CH-1:0]   stat_q, stat_d;
    logic                irq_q, irq_d;
    logic [CNT_W-1:0]    cnt_q  [NUM_CH];
    logic [CNT_W-1:0]    cnt_d  [NUM_CH];
    logic [CNT_W-1:0]    snap_q [NUM_CH];
    logic [CNT_W-1:0]    snap_d [NUM_CH];

    logic [WIN_W-1:0]    off;
    logic                in_win, accept, wr;
    logic                lane0_ctrl, lane0_irqen, lane0_stat;
    logic                snap_cmd, clr_cmd;
    logic [NUM_CH-1:0]   ev_set, w1c;
    logic [31:0]         rdata;
    logic                unused_ok;

    assign off    = wbs_adr_i[WIN_W-1:0];
    assign in_win = (wbs_adr_i[31:WIN_W] == BASE_ADDR[31:WIN_W]);
    // ack_q in the accept term is what forces the idle cycle between acks
    assign accept = wbs_cyc_i & wbs_stb_i & ~ack_q & in_win;
    assign wr     = accept & wbs_we_i;

    // All writable bits live in byte lane 0, so only sel[0] gates them
    assign lane0_ctrl  = wr & wbs_sel_i[0] & (off == OFF_CTRL);
    assign lane0_irqen = wr & wbs_sel_i[0] & (off == OFF_IRQEN);
    assign lane0_stat  = wr & wbs_sel_i[0] & (off == OFF_ISTAT);

    assign snap_cmd = lane0_ctrl & wbs_dat_i[2];
    assign clr_cmd  = lane0_ctrl & wbs_dat_i[3];
    assign start_d  = lane0_ctrl & wbs_dat_i[1];
    assign enable_d = lane0_ctrl ? wbs_dat_i[0] : enable_q;
    assign irq_en_d = lane0_irqen ? wbs_dat_i[NUM_CH-1:0] : irq_en_q;

    assign ev_set = ch_event_i & {NUM_CH{enable_q}};
    assign w1c    = lane0_stat ? wbs_dat_i[NUM_CH-1:0] : '0;
    // Set is OR'd after the clear so a same-cycle event wins over W1C
    assign stat_d = (stat_q & ~w1c) | ev_set;
    assign irq_d  = |(stat_q & irq_en_q);

    assign unused_ok = ^{wbs_dat_i, wbs_sel_i};

    // Snapshot reads the pre-update count; clear takes priority over increment
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            snap_d[i] = snap_cmd ? cnt_q[i] : snap_q[i];
            cnt_d[i]  = cnt_q[i];
            if (clr_cmd) begin
                cnt_d[i] = '0;
            end else if (ev_set[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_ID:     rdata = 32'h4849_4348;
            OFF_VER:    rdata = VERSION;
            OFF_CAPS:   rdata = {8'h0, 8'(CNT_W), 8'h0, 8'(NUM_CH)};
            OFF_CTRL:   rdata[0] = enable_q;
            OFF_IRQEN:  rdata[NUM_CH-1:0] = irq_en_q;
            OFF_STATUS: rdata[7:0] = core_status;
            OFF_ISTAT:  rdata[NUM_CH-1:0] = stat_q;
            default: begin
                if (off[1:0] == 2'b00) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (off[6:2] == 5'(i)) begin
                            if (off[WIN_W-1:7] == OFF_CNT[WIN_W-1:7]) begin
                                rdata[CNT_W-1:0] = cnt_q[i];
                            end else if (off[WIN_W-1:7] == OFF_SNAP[WIN_W-1:7]) begin
                                rdata[CNT_W-1:0] = snap_q[i];
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            enable_q <= 1'b0;
            start_q  <= 1'b0;
            irq_en_q <= '0;
            stat_q   <= '0;
            irq_q    <= 1'b0;
            cnt_q    <= '{default: '0};
            snap_q   <= '{default: '0};
        end else begin
            ack_q    <= accept;
            if (accept) begin
                dat_q <= rdata;
            end
            enable_q <= enable_d;
            start_q  <= start_d;
            irq_en_q <= irq_en_d;
            stat_q   <= stat_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign ctrl_enable = enable_q;
    assign ctrl_start  = start_q;
    assign irq_en      = irq_en_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_home_inventory_wb_regs.sv
// Bench for home_inventory_wb_regs: a default instance checked against a
// behavioural model, plus a CNT_W=4 instance at 0x3000_2000 for saturation.
module tb_home_inventory_wb_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic [7:0]  core_status;
    logic [3:0]  ev_a, ev_b;

    logic        ack_a, en_a, start_a, irq_a;
    logic [31:0] dat_a;
    logic [3:0]  irqen_a;
    logic        ack_b, en_b, start_b, irq_b;
    logic [31:0] dat_b;
    logic [3:0]  irqen_b;
    logic        ack;
    logic [31:0] rdat;

    always #5 clk = ~clk;

    home_inventory_wb_regs u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
        .core_status(core_status), .ch_event_i(ev_a),
        .ctrl_enable(en_a), .ctrl_start(start_a), .irq_en(irqen_a), .irq_o(irq_a)
    );

    home_inventory_wb_regs #(.CNT_W(4), .BASE_ADDR(32'h3000_2000)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
        .core_status(core_status), .ch_event_i(ev_b),
        .ctrl_enable(en_b), .ctrl_start(start_b), .irq_en(irqen_b), .irq_o(irq_b)
    );

    assign ack  = ack_a | ack_b;
    assign rdat = ack_b ? dat_b : dat_a;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of the default instance (advanced once per clock)
    localparam int unsigned CMAX = 65535;
    int unsigned cnt_m [4];
    int unsigned snap_m [4];
    int unsigned stat_m, irqen_m;
    bit          enable_m, start_m, irq_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            cnt_m[i]  = 0;
            snap_m[i] = 0;
        end
        stat_m = 0; irqen_m = 0; enable_m = 0; start_m = 0; irq_m = 0;
    endtask

    function automatic int unsigned model_rd(input int unsigned off);
        int unsigned r;
        r = 0;
        if (off == 'h000) r = 32'h4849_4348;
        else if (off == 'h004) r = 32'h2;
        else if (off == 'h008) r = 32'h0010_0004;
        else if (off == 'h100) r = enable_m;
        else if (off == 'h104) r = irqen_m;
        else if (off == 'h108) r = core_status;
        else if (off == 'h10C) r = stat_m;
        else if (off >= 'h200 && off < 'h210 && off % 4 == 0) r = cnt_m[(off - 'h200) / 4];
        else if (off >= 'h280 && off < 'h290 && off % 4 == 0) r = snap_m[(off - 'h280) / 4];
        return r;
    endfunction

    task automatic model_step(input logic [3:0] ev, input bit wr, input int unsigned off,
                              input logic [31:0] d, input logic [3:0] s);
        bit ctrl_w, snap, clr;
        int unsigned set, w1c;
        irq_m   = (stat_m & irqen_m) != 0;
        ctrl_w  = wr && off == 'h100 && s[0];
        snap    = ctrl_w && d[2];
        clr     = ctrl_w && d[3];
        start_m = ctrl_w && d[1];
        set     = enable_m ? 32'(ev) : 0;
        for (int i = 0; i < 4; i++) begin
            if (snap) snap_m[i] = cnt_m[i];
            if (clr) cnt_m[i] = 0;
            else if (set[i] && cnt_m[i] < CMAX) cnt_m[i] = cnt_m[i] + 1;
        end
        w1c    = (wr && off == 'h10C && s[0]) ? (d & 32'hF) : 0;
        stat_m = (stat_m & ~w1c) | set;
        if (ctrl_w) enable_m = d[0];
        if (wr && off == 'h104 && s[0]) irqen_m = d & 32'hF;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".enable"}, 32'(en_a), 32'(enable_m));
        chk({tag, ".start"}, 32'(start_a), 32'(start_m));
        chk({tag, ".irq_en"}, 32'(irqen_a), irqen_m);
        chk({tag, ".irq_o"}, 32'(irq_a), 32'(irq_m));
    endtask

    // One transfer: accept on the next edge, ack seen one negedge later, then a gap cycle
    task automatic xfer(input string tag, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] ev, output logic [31:0] rd);
        bit in_a, in_b;
        int unsigned exp;
        in_a = (a[31:12] == 20'h30000);
        in_b = (a[31:12] == 20'h30002);
        core_status = 8'($urandom);
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s; ev_a = ev;
        exp = model_rd(32'(a[11:0]));
        model_step(ev, w && in_a, 32'(a[11:0]), d, s);
        @(negedge clk);
        rd = rdat;
        chk({tag, ".ack"}, 32'(ack), 32'(in_a | in_b));
        if (in_a && !w) chk({tag, ".rdata"}, rdat, exp);
        chk_outs(tag);
        cyc = 0; stb = 0; we = 0; ev_a = 0;
        model_step(4'h0, 1'b0, 0, 32'h0, 4'h0);
        @(negedge clk);
        chk({tag, ".gap"}, 32'(ack), 32'h0);
        chk_outs({tag, ".gap"});
    endtask

    task automatic idle(input logic [3:0] eva, input logic [3:0] evb, input int n);
        for (int k = 0; k < n; k++) begin
            ev_a = eva; ev_b = evb;
            model_step(eva, 1'b0, 0, 32'h0, 4'h0);
            @(negedge clk);
            chk_outs("idle");
        end
        ev_a = 0; ev_b = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".ack"}, 32'(ack_a), 32'h0);
        chk({tag, ".dat"}, dat_a, 32'h0);
        chk({tag, ".outs"}, {26'h0, en_a, start_a, irqen_a}, 32'h0);
        chk({tag, ".irq"}, 32'(irq_a), 32'h0);
        chk({tag, ".b"}, {dat_b[24:0], ack_b, en_b, start_b, irqen_b}, 32'h0);
    endtask

    localparam logic [31:0] A = 32'h3000_0000;
    localparam logic [31:0] B = 32'h3000_2000;

    initial begin
        logic [31:0] r;
        int unsigned offs [20];
        offs = '{'h000, 'h004, 'h008, 'h100, 'h104, 'h108, 'h10C, 'h200, 'h204, 'h208,
                 'h20C, 'h210, 'h21C, 'h280, 'h284, 'h28C, 'h290, 'h102, 'h300, 'h0FC};

        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
        core_status = 0; ev_a = 0; ev_b = 0;
        model_reset();
        #1 chk_reset_outs("T1.por");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // T1: reset asserted while a read has just been acked
        cyc = 1; stb = 1; we = 0; adr = A; sel = 4'hF;
        @(posedge clk);
        #1 rst_n = 0;
        #1 chk_reset_outs("T1.midread");
        @(negedge clk);
        cyc = 0; stb = 0; rst_n = 1;
        model_reset();
        @(negedge clk);
        chk_reset_outs("T1.release");
        model_step(4'h0, 1'b0, 0, 32'h0, 4'h0);
        xfer("T1.id", 0, A + 'h000, 0, 4'hF, 0, r);   chk("T1.id_const", r, 32'h4849_4348);
        xfer("T1.ver", 0, A + 'h004, 0, 4'hF, 0, r);  chk("T1.ver_const", r, 32'h2);
        xfer("T1.caps", 0, A + 'h008, 0, 4'hF, 0, r); chk("T1.caps_const", r, 32'h0010_0004);

        // T2: held request acks every other cycle; out-of-window never acks
        cyc = 1; stb = 1; we = 0; adr = A; sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("T2.ack%0d", k), 32'(ack), 32'(k % 2));
            model_step(4'h0, 1'b0, 0, 32'h0, 4'h0);
            @(negedge clk);
        end
        cyc = 0; stb = 0;
        model_step(4'h0, 1'b0, 0, 32'h0, 4'h0);
        @(negedge clk);
        chk("T2.drop", 32'(ack), 32'h0);
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_1100; dat_i = 32'h3;
        for (int k = 0; k < 6; k++) begin
            model_step(4'h0, 1'b0, 0, 32'h0, 4'h0);
            @(negedge clk);
            chk($sformatf("T2.oow%0d", k), 32'(ack), 32'h0);
            chk_outs("T2.oow");
        end
        cyc = 0; stb = 0; we = 0;

        // T3: byte lanes
        xfer("T3.w0", 1, A + 'h104, 32'hF, 4'b0000, 0, r);
        xfer("T3.r0", 0, A + 'h104, 0, 4'hF, 0, r);  chk("T3.sel0", r, 32'h0);
        xfer("T3.w1", 1, A + 'h104, 32'hF, 4'b0001, 0, r);
        xfer("T3.r1", 0, A + 'h104, 0, 4'hF, 0, r);  chk("T3.sel1", r, 32'hF);
        xfer("T3.w2", 1, A + 'h104, 32'hFFFF_FFFF, 4'hF, 0, r);
        xfer("T3.r2", 0, A + 'h104, 0, 4'hF, 0, r);  chk("T3.all", r, 32'hF);
        xfer("T3.wro", 1, A + 'h000, 32'h0, 4'hF, 0, r);
        xfer("T3.rro", 0, A + 'h000, 0, 4'hF, 0, r);

        // T4: counters, IRQ status and same-cycle interactions
        xfer("T4.en", 1, A + 'h100, 32'h1, 4'hF, 0, r);
        xfer("T4.ie", 1, A + 'h104, 32'h4, 4'hF, 0, r);
        for (int k = 0; k < 5; k++) begin
            idle(4'h4, 4'h0, 1);
            idle(4'h0, 4'h0, 1);
        end
        xfer("T4.cnt", 0, A + 'h208, 0, 4'hF, 0, r);   chk("T4.cnt5", r, 32'd5);
        xfer("T4.st", 0, A + 'h10C, 0, 4'hF, 0, r);    chk("T4.st4", r, 32'h4);
        chk("T4.irq", 32'(irq_a), 32'h1);
        xfer("T4.w1cev", 1, A + 'h10C, 32'h4, 4'hF, 4'h4, r);
        xfer("T4.st2", 0, A + 'h10C, 0, 4'hF, 0, r);   chk("T4.setwins", r, 32'h4);
        xfer("T4.w1c", 1, A + 'h10C, 32'h4, 4'hF, 0, r);
        xfer("T4.st3", 0, A + 'h10C, 0, 4'hF, 0, r);   chk("T4.cleared", r, 32'h0);
        chk("T4.irq0", 32'(irq_a), 32'h0);
        xfer("T4.rdev", 0, A + 'h208, 0, 4'hF, 4'h4, r); chk("T4.preinc", r, 32'd6);
        xfer("T4.snapev", 1, A + 'h100, 32'h5, 4'hF, 4'h4, r);
        xfer("T4.snap", 0, A + 'h288, 0, 4'hF, 0, r);  chk("T4.snappre", r, 32'd7);
        xfer("T4.clrev", 1, A + 'h100, 32'h9, 4'hF, 4'h4, r);
        xfer("T4.clr", 0, A + 'h208, 0, 4'hF, 0, r);   chk("T4.clrwins", r, 32'd0);
        xfer("T4.dis", 1, A + 'h100, 32'h0, 4'hF, 0, r);
        idle(4'hF, 4'h0, 3);
        xfer("T4.hold", 0, A + 'h200, 0, 4'hF, 0, r);  chk("T4.hold0", r, 32'd0);

        // T5: 4-bit counters saturate; snap+clear in one write
        xfer("T5.en", 1, B + 'h100, 32'h1, 4'hF, 0, r);
        idle(4'h0, 4'h1, 20);
        xfer("T5.cnt", 0, B + 'h200, 0, 4'hF, 0, r);   chk("T5.sat", r, 32'hF);
        xfer("T5.sc", 1, B + 'h100, 32'hD, 4'hF, 0, r);
        xfer("T5.snap", 0, B + 'h280, 0, 4'hF, 0, r);  chk("T5.snapF", r, 32'hF);
        xfer("T5.cnt2", 0, B + 'h200, 0, 4'hF, 0, r);  chk("T5.cnt0", r, 32'h0);
        xfer("T5.ctrl", 0, B + 'h100, 0, 4'hF, 0, r);  chk("T5.ctrl1", r, 32'h1);

        // T6: start pulse (single-cycle ctrl_start checked inside xfer)
        xfer("T6.start", 1, A + 'h100, 32'h3, 4'hF, 0, r);
        xfer("T6.ctrl", 0, A + 'h100, 0, 4'hF, 0, r);  chk("T6.ctrl1", r, 32'h1);
        chk("T6.enable", 32'(en_a), 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            int unsigned op, o;
            logic [3:0] ev, s;
            logic [31:0] d;
            op = $urandom_range(0, 2);
            ev = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            o  = offs[$urandom_range(0, 19)];
            s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            d  = $urandom;
            if (op == 0) idle(ev, 4'h0, $urandom_range(1, 3));
            else if (op == 1) xfer("RND.rd", 0, A + o, 0, s, ev, r);
            else xfer("RND.wr", 1, A + o, d, s, ev, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
